// File: rtl/top_pkg.sv
// Shared types and constants for the 6502 platform: memory map, bus types and CPU encodings.
package top_pkg;
  localparam int RAM_AW = 12;
  localparam int ROM_AW = 12;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  byte_t;

  localparam addr_t ROM_BASE     = 16'hF000;
  localparam addr_t RESET_VEC_LO = 16'hFFFC;

  typedef enum logic [1:0] {REG_A = 2'd0, REG_X = 2'd1, REG_Y = 2'd2, REG_SP = 2'd3} reg_sel_e;

  typedef enum logic [3:0] {
    S_VEC_LO, S_VEC_HI, S_FETCH, S_OP1, S_OP2,
    S_WRITE, S_PUSH_LO, S_JUMP, S_POP_LO, S_POP_HI
  } cpu_state_e;

  localparam byte_t OP_LDA_IMM = 8'hA9;
  localparam byte_t OP_LDX_IMM = 8'hA2;
  localparam byte_t OP_STA_ZP  = 8'h85;
  localparam byte_t OP_STA_ABS = 8'h8D;
  localparam byte_t OP_JMP_ABS = 8'h4C;
  localparam byte_t OP_JSR     = 8'h20;
  localparam byte_t OP_RTS     = 8'h60;
  localparam byte_t OP_TXS     = 8'h9A;
endpackage

// File: rtl/top_if.sv
// CPU <-> memory bus: address/write data/write strobe from the CPU, read data back.
interface top_if;
  import top_pkg::*;
  addr_t addr;
  byte_t wdata;
  byte_t rdata;
  logic  memwrite;

  modport master (output addr, output wdata, output memwrite, input rdata);
  modport slave  (input addr, input wdata, input memwrite, output rdata);
endinterface

// File: rtl/top_cpu.sv
// Compact 6502-subset CPU (LDA#, LDX#, STA zp/abs, JMP, JSR, RTS, TXS; other opcodes act as NOP).
// Hierarchy chip.core.dp.regfile.reg_file[] holds A, X, Y, SP in that order.
module cpu_regfile
  import top_pkg::*;
(
  input  logic     clk,
  input  logic     srst,
  input  logic     we,
  input  reg_sel_e wsel,
  input  byte_t    wval,
  output byte_t    a,
  output byte_t    x,
  output byte_t    sp
);
  byte_t reg_file [0:3];

  always_ff @(posedge clk) begin
    if (srst) begin
      reg_file[0] <= 8'h00;
      reg_file[1] <= 8'h00;
      reg_file[2] <= 8'h00;
      reg_file[3] <= 8'hFF;
    end else if (we) begin
      reg_file[wsel] <= wval;
    end
  end

  assign a  = reg_file[REG_A];
  assign x  = reg_file[REG_X];
  assign sp = reg_file[REG_SP];
endmodule

module cpu_dp
  import top_pkg::*;
(
  input  logic     clk,
  input  logic     srst,
  input  logic     we,
  input  reg_sel_e wsel,
  input  byte_t    wval,
  output byte_t    a,
  output byte_t    x,
  output byte_t    sp
);
  cpu_regfile regfile (
    .clk(clk), .srst(srst), .we(we), .wsel(wsel), .wval(wval),
    .a(a), .x(x), .sp(sp)
  );
endmodule

module cpu_core
  import top_pkg::*;
(
  input  logic  clk,
  input  logic  srst,
  input  byte_t rdata,
  output addr_t addr_q,
  output byte_t wdata_q,
  output logic  memwrite_q
);
  cpu_state_e state_q;
  addr_t      pc_q, tgt_q;
  byte_t      op_q, lo_q;
  logic       rf_we;
  reg_sel_e   rf_sel;
  byte_t      rf_val;
  byte_t      a, x, sp;

  cpu_dp dp (
    .clk(clk), .srst(srst), .we(rf_we), .wsel(rf_sel), .wval(rf_val),
    .a(a), .x(x), .sp(sp)
  );

  // Register writes land on the same edge that samples rdata, so they are decoded combinationally.
  always_comb begin
    rf_we  = 1'b0;
    rf_sel = REG_A;
    rf_val = rdata;
    case (state_q)
      S_FETCH: begin
        if (rdata == OP_TXS) begin
          rf_we = 1'b1; rf_sel = REG_SP; rf_val = x;
        end else if (rdata == OP_RTS) begin
          rf_we = 1'b1; rf_sel = REG_SP; rf_val = sp + 8'd1;
        end
      end
      S_OP1: begin
        if (op_q == OP_LDA_IMM) begin
          rf_we = 1'b1; rf_sel = REG_A;
        end else if (op_q == OP_LDX_IMM) begin
          rf_we = 1'b1; rf_sel = REG_X;
        end
      end
      S_OP2: begin
        if (op_q == OP_JSR) begin
          rf_we = 1'b1; rf_sel = REG_SP; rf_val = sp - 8'd1;
        end
      end
      S_PUSH_LO: begin
        rf_we = 1'b1; rf_sel = REG_SP; rf_val = sp - 8'd1;
      end
      S_POP_LO: begin
        rf_we = 1'b1; rf_sel = REG_SP; rf_val = sp + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= S_VEC_LO;
      addr_q     <= RESET_VEC_LO;
      wdata_q    <= 8'h00;
      memwrite_q <= 1'b0;
      pc_q       <= 16'h0000;
      tgt_q      <= 16'h0000;
      op_q       <= 8'h00;
      lo_q       <= 8'h00;
    end else begin
      memwrite_q <= 1'b0;
      case (state_q)
        S_VEC_LO: begin
          lo_q    <= rdata;
          addr_q  <= RESET_VEC_LO + 16'd1;
          state_q <= S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_q    <= {rdata, lo_q};
          addr_q  <= {rdata, lo_q};
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          op_q <= rdata;
          case (rdata)
            OP_RTS: begin
              addr_q  <= {8'h01, sp + 8'd1};
              state_q <= S_POP_LO;
            end
            OP_LDA_IMM, OP_LDX_IMM, OP_STA_ZP, OP_STA_ABS, OP_JMP_ABS, OP_JSR: begin
              pc_q    <= pc_q + 16'd1;
              addr_q  <= pc_q + 16'd1;
              state_q <= S_OP1;
            end
            default: begin
              pc_q   <= pc_q + 16'd1;
              addr_q <= pc_q + 16'd1;
            end
          endcase
        end
        S_OP1: begin
          pc_q <= pc_q + 16'd1;
          lo_q <= rdata;
          case (op_q)
            OP_STA_ZP: begin
              addr_q     <= {8'h00, rdata};
              wdata_q    <= a;
              memwrite_q <= 1'b1;
              state_q    <= S_WRITE;
            end
            OP_STA_ABS, OP_JMP_ABS, OP_JSR: begin
              addr_q  <= pc_q + 16'd1;
              state_q <= S_OP2;
            end
            default: begin
              addr_q  <= pc_q + 16'd1;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_OP2: begin
          case (op_q)
            OP_STA_ABS: begin
              pc_q       <= pc_q + 16'd1;
              addr_q     <= {rdata, lo_q};
              wdata_q    <= a;
              memwrite_q <= 1'b1;
              state_q    <= S_WRITE;
            end
            OP_JMP_ABS: begin
              pc_q    <= {rdata, lo_q};
              addr_q  <= {rdata, lo_q};
              state_q <= S_FETCH;
            end
            default: begin
              // JSR pushes the address of its own last byte, high byte first.
              tgt_q      <= {rdata, lo_q};
              addr_q     <= {8'h01, sp};
              wdata_q    <= pc_q[15:8];
              memwrite_q <= 1'b1;
              state_q    <= S_PUSH_LO;
            end
          endcase
        end
        S_PUSH_LO: begin
          addr_q     <= {8'h01, sp};
          wdata_q    <= pc_q[7:0];
          memwrite_q <= 1'b1;
          state_q    <= S_JUMP;
        end
        S_JUMP: begin
          pc_q    <= tgt_q;
          addr_q  <= tgt_q;
          state_q <= S_FETCH;
        end
        S_WRITE: begin
          addr_q  <= pc_q;
          state_q <= S_FETCH;
        end
        S_POP_LO: begin
          lo_q    <= rdata;
          addr_q  <= {8'h01, sp + 8'd1};
          state_q <= S_POP_HI;
        end
        S_POP_HI: begin
          pc_q    <= {rdata, lo_q} + 16'd1;
          addr_q  <= {rdata, lo_q} + 16'd1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end
endmodule

module chip
  import top_pkg::*;
(
  input  logic  ph1,
  input  logic  reset,
  output addr_t addr,
  input  byte_t rdata,
  output byte_t wdata,
  output logic  memwrite
);
  cpu_core core (
    .clk(ph1), .srst(reset), .rdata(rdata),
    .addr_q(addr), .wdata_q(wdata), .memwrite_q(memwrite)
  );
endmodule

// File: rtl/top_sys_mem.sv
// Memory subsystem: top-aligned ROM, RAM at $0000, combinational read decode and RAM write path.
// RAM_MIRROR_EN: when defined, RAM is mirrored across all of $0000..ROM_BASE-1.
module sys_mem #(
  parameter int              RAM_AW   = top_pkg::RAM_AW,
  parameter int              ROM_AW   = top_pkg::ROM_AW,
  parameter top_pkg::addr_t  ROM_BASE = top_pkg::ROM_BASE
) (
  input  logic  clk,
  input  logic  srst,
  top_if.slave  bus
);
  top_pkg::byte_t ROM [0:2**ROM_AW-1];
  top_pkg::byte_t RAM [0:2**RAM_AW-1];

  logic rom_hit;
  logic ram_hit;

  always_comb begin
    rom_hit = (bus.addr >= ROM_BASE);
`ifdef RAM_MIRROR_EN
    ram_hit = !rom_hit;
`else
    ram_hit = ((bus.addr >> RAM_AW) == '0);
`endif
    bus.rdata = 8'h00;
    if (rom_hit) begin
      bus.rdata = ROM[bus.addr[ROM_AW-1:0]];
    end else if (ram_hit) begin
      bus.rdata = RAM[bus.addr[RAM_AW-1:0]];
    end
  end

  // Writes during reset are dropped so an aborted instruction cannot corrupt RAM.
  always_ff @(posedge clk) begin
    if (bus.memwrite && !srst && ram_hit) begin
      RAM[bus.addr[RAM_AW-1:0]] <= bus.wdata;
    end
  end
endmodule

// File: rtl/top.sv
// 6502 platform top: wires CPU `chip` to memory `mem` over the internal bus.
// Honours RAM_MIRROR_EN through sys_mem.
module top #(
  parameter int             RAM_AW   = top_pkg::RAM_AW,
  parameter int             ROM_AW   = top_pkg::ROM_AW,
  parameter top_pkg::addr_t ROM_BASE = top_pkg::ROM_BASE
) (
  input  logic ph1,
  input  logic reset
);
  top_if bus ();

  chip chip (
    .ph1(ph1), .reset(reset),
    .addr(bus.addr), .rdata(bus.rdata), .wdata(bus.wdata), .memwrite(bus.memwrite)
  );

  sys_mem #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .ROM_BASE(ROM_BASE)) mem (
    .clk(ph1), .srst(reset), .bus(bus.slave)
  );
endmodule

// File: tb/tb_top.sv
// Directed bench for the 6502 platform top: decode, reset hold, stack, JSR/RTS and ROM protection.
module tb_top;
`ifdef RAM_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic ph1 = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #10 ph1 = ~ph1;

  top dut (.ph1(ph1), .reset(reset));

  top_if probe ();
  assign probe.addr     = dut.bus.addr;
  assign probe.wdata    = dut.bus.wdata;
  assign probe.rdata    = dut.bus.rdata;
  assign probe.memwrite = dut.bus.memwrite;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: got %h", tag, got);
    end
  endtask

  task automatic rom_w(input int a, input logic [7:0] d);
    dut.mem.ROM[a[11:0]] = d;
  endtask

  task automatic load_prog(input logic [7:0] prog[$]);
    foreach (prog[i]) rom_w(i, prog[i]);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ph1);
  endtask

  task automatic read_at(input string tag, input logic [15:0] a, input logic [7:0] exp);
    force dut.bus.addr = a;
    #1;
    check_eq(tag, {8'h00, probe.rdata}, {8'h00, exp});
    release dut.bus.addr;
  endtask

  logic [7:0] prog[$];
  int         waited;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dut.mem.ROM[i] = 8'h00;
      dut.mem.RAM[i] = 8'h00;
    end
    rom_w(12'hFFC, 8'h00);
    rom_w(12'hFFD, 8'hF0);
    rom_w(12'h123, 8'h5C);
    dut.mem.RAM[64]   = 8'h3C;
    dut.mem.RAM[0]    = 8'hA1;
    dut.mem.RAM[4095] = 8'h7E;

    reset = 1'b1;
    cycles(5);
    check_eq("reset_sp",       {8'h00, dut.chip.core.dp.regfile.reg_file[3]}, 16'h00FF);
    check_eq("reset_addr",     probe.addr, 16'hFFFC);
    check_eq("reset_memwrite", {15'd0, probe.memwrite}, 16'h0000);

    // Read decode with the CPU held in reset.
    read_at("rd_rom_f123", 16'hF123, 8'h5C);
    read_at("rd_ram_0040", 16'h0040, 8'h3C);
    read_at("rd_ram_0fff", 16'h0FFF, 8'h7E);
    read_at("rd_1000",     16'h1000, MIRROR ? 8'hA1 : 8'h00);
    read_at("rd_8000",     16'h8000, MIRROR ? 8'hA1 : 8'h00);
    read_at("rd_efff",     16'hEFFF, MIRROR ? 8'h7E : 8'h00);
    read_at("rd_vec_hi",   16'hFFFD, 8'hF0);

    // Write strobe forced during reset must not reach RAM.
    force dut.bus.addr = 16'h0040;
    force dut.bus.wdata = 8'hEE;
    force dut.bus.memwrite = 1'b1;
    cycles(3);
    release dut.bus.addr;
    release dut.bus.wdata;
    release dut.bus.memwrite;
    #1;
    check_eq("reset_hold_ram64", {8'h00, dut.mem.RAM[64]}, 16'h003C);

    // Stack: JSR $F010 from $F000 into a self-loop.
    prog = '{8'h20, 8'h10, 8'hF0};
    load_prog(prog);
    prog = '{8'h4C, 8'h10, 8'hF0};
    for (int i = 0; i < 3; i++) rom_w(16 + i, prog[i]);
    reset = 1'b0;
    @(negedge ph1);
    check_eq("vec_fetch_hi_addr", probe.addr, 16'hFFFD);
    @(negedge ph1);
    check_eq("vec_start_addr", probe.addr, 16'hF000);
    cycles(20);
    check_eq("stack_ram511", {8'h00, dut.mem.RAM[511]}, 16'h00F0);
    check_eq("stack_ram510", {8'h00, dut.mem.RAM[510]}, 16'h0002);
    check_eq("stack_sp",     {8'h00, dut.chip.core.dp.regfile.reg_file[3]}, 16'h00FD);

    // JSR/RTS then LDA #$42 / STA $40.
    reset = 1'b1;
    cycles(5);
    check_eq("ram_survives_reset", {8'h00, dut.mem.RAM[511]}, 16'h00F0);
    prog = '{8'h20, 8'h10, 8'hF0, 8'hA9, 8'h42, 8'h85, 8'h40, 8'h4C, 8'h07, 8'hF0};
    load_prog(prog);
    rom_w(16, 8'h60);
    reset = 1'b0;
    waited = 0;
    while (waited < 60 && dut.mem.RAM[64] != 8'h42) begin
      @(negedge ph1);
      waited++;
    end
    check_eq("jsr_rts_sta40", {8'h00, dut.mem.RAM[64]}, 16'h0042);
    check_eq("rts_sp",        {8'h00, dut.chip.core.dp.regfile.reg_file[3]}, 16'h00FF);
    check_eq("reg_a",         {8'h00, dut.chip.core.dp.regfile.reg_file[0]}, 16'h0042);

    // ROM protect and mirror write: STA $F000, STA $1040, then STA $41 as completion marker.
    reset = 1'b1;
    cycles(5);
    dut.mem.RAM[64] = 8'h3C;
    dut.mem.RAM[65] = 8'h00;
    prog = '{8'hA9, 8'hAA, 8'h8D, 8'h00, 8'hF0, 8'hA9, 8'h5A, 8'h8D, 8'h40, 8'h10,
             8'hA9, 8'h11, 8'h85, 8'h41, 8'h4C, 8'h0E, 8'hF0};
    load_prog(prog);
    reset = 1'b0;
    waited = 0;
    while (waited < 80 && dut.mem.RAM[65] != 8'h11) begin
      @(negedge ph1);
      waited++;
    end
    check_eq("prog_c_done", {8'h00, dut.mem.RAM[65]}, 16'h0011);
    check_eq("rom_protect", {8'h00, dut.mem.ROM[0]}, 16'h00A9);
    check_eq("bus_known",   {15'd0, $isunknown(probe.rdata)}, 16'h0000);
    check_eq("mirror_ram64", {8'h00, dut.mem.RAM[64]}, MIRROR ? 16'h005A : 16'h003C);
    reset = 1'b1;
    cycles(2);
    read_at("rd_back_0040", 16'h0040, MIRROR ? 8'h5A : 8'h3C);
    read_at("rd_back_1040", 16'h1040, MIRROR ? 8'h5A : 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
